// File: rtl/round_ctrl_if.sv
// Player-side signal bundle for the reaction-game referee: raw buttons and
// scorer position in, round result and light/game status out.
interface round_ctrl_if;
    logic       pbl;
    logic       pbr;
    logic [6:0] score;
    logic       leds_on;
    logic       winrnd;
    logic       right;
    logic       tie;
    logic       game_ovr;

    modport master (
        output pbl, pbr, score,
        input  leds_on, winrnd, right, tie, game_ovr
    );

    modport slave (
        input  pbl, pbr, score,
        output leds_on, winrnd, right, tie, game_ovr
    );
endinterface

// File: rtl/round_ctrl.sv
// Referee FSM for the reaction game: random delay, lights, first-press decision.
// Optional build macro ROUND_TIMEOUT_EN adds a forced tie after TIMEOUT lit cycles.
module round_ctrl #(
    parameter int          DELAY_MIN = 16,
    parameter int          DELAY_W   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    round_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(DELAY_MIN + (1 << DELAY_W));

    typedef enum logic [2:0] {
        S_RELEASE, S_ARM, S_WAIT, S_LIGHT, S_REPORT, S_DONE
    } state_t;

    state_t           state, state_nx;
    logic             pbl_meta, pbr_meta, sl, sr;
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] cnt;
    logic             hit_right, hit_tie, hit_lit;
    logic             rpt_right, rpt_tie, rpt_lit;
    logic             leds_on_d, winrnd_d, right_d, tie_d, game_ovr_d;
    logic             leds_on_q, winrnd_q, right_q, tie_q, game_ovr_q;
    logic             win_pat, lit_hold, timed_out;

    // Button synchronizers and free-running LFSR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pbl_meta <= 1'b0;
            pbr_meta <= 1'b0;
            sl       <= 1'b0;
            sr       <= 1'b0;
            lfsr     <= LFSR_SEED;
        end else begin
            pbl_meta <= bus.pbl;
            pbr_meta <= bus.pbr;
            sl       <= pbl_meta;
            sr       <= pbr_meta;
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_ARM)
            cnt <= CNT_W'(DELAY_MIN) + CNT_W'(lfsr[DELAY_W-1:0]);
        else if (state == S_WAIT && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

`ifdef ROUND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (state == S_LIGHT)
            tcnt <= tcnt + TO_W'(1);
        else
            tcnt <= '0;
    end

    assign timed_out = (tcnt == TO_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    assign win_pat = (bus.score == 7'b1110000) || (bus.score == 7'b0000111);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_RELEASE;
        else
            state <= state_nx;
    end

    // Next state; a press outranks the delay expiring in the same cycle
    always_comb begin
        state_nx  = state;
        hit_right = 1'b0;
        hit_tie   = 1'b0;
        hit_lit   = 1'b0;
        case (state)
            S_RELEASE: if (!sl && !sr) state_nx = win_pat ? S_DONE : S_ARM;
            S_ARM:     state_nx = S_WAIT;
            S_WAIT: begin
                if (sl || sr) begin
                    state_nx  = S_REPORT;
                    hit_right = sr & ~sl;
                    hit_tie   = sl & sr;
                end else if (cnt == '0) begin
                    state_nx = S_LIGHT;
                end
            end
            S_LIGHT: begin
                hit_lit = 1'b1;
                if (sl || sr) begin
                    state_nx  = S_REPORT;
                    hit_right = sr & ~sl;
                    hit_tie   = sl & sr;
                end else if (timed_out) begin
                    state_nx = S_REPORT;
                    hit_tie  = 1'b1;
                end
            end
            S_REPORT:  state_nx = S_RELEASE;
            S_DONE:    state_nx = S_DONE;
            default:   state_nx = S_RELEASE;
        endcase
    end

    // Round verdict captured on the way into REPORT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_right <= 1'b0;
            rpt_tie   <= 1'b0;
            rpt_lit   <= 1'b0;
        end else if (state != S_REPORT && state_nx == S_REPORT) begin
            rpt_right <= hit_right;
            rpt_tie   <= hit_tie;
            rpt_lit   <= hit_lit;
        end
    end

    // Outputs; qualifiers hold through the winrnd cycle and one cycle beyond
    always_comb begin
        lit_hold   = (state == S_REPORT) || winrnd_q;
        leds_on_d  = (state == S_LIGHT) || (lit_hold && rpt_lit);
        right_d    = lit_hold && rpt_right;
        tie_d      = lit_hold && rpt_tie;
        winrnd_d   = (state == S_REPORT);
        game_ovr_d = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_on_q  <= 1'b0;
            winrnd_q   <= 1'b0;
            right_q    <= 1'b0;
            tie_q      <= 1'b0;
            game_ovr_q <= 1'b0;
        end else begin
            leds_on_q  <= leds_on_d;
            winrnd_q   <= winrnd_d;
            right_q    <= right_d;
            tie_q      <= tie_d;
            game_ovr_q <= game_ovr_d;
        end
    end

    assign bus.leds_on  = leds_on_q;
    assign bus.winrnd   = winrnd_q;
    assign bus.right    = right_q;
    assign bus.tie      = tie_q;
    assign bus.game_ovr = game_ovr_q;

endmodule
